// File: rtl/kavach_pkg.sv
// Shared types for the Kavach threat responder: response states, severity codes
// and the layout of the anomaly flag vector.
package kavach_pkg;

    typedef enum logic [2:0] {
        RESP_IDLE     = 3'd0,
        RESP_ALERT    = 3'd1,
        RESP_CONTAIN  = 3'd2,
        RESP_LOCKDOWN = 3'd3,
        RESP_LOCKED   = 3'd4,
        RESP_COOLDOWN = 3'd5
    } resp_state_t;

    typedef enum logic [1:0] {
        SEV_NONE = 2'b00,
        SEV_LOW  = 2'b01,
        SEV_MED  = 2'b10,
        SEV_HIGH = 2'b11
    } severity_t;

    // Bit positions, MSB first: nmi=5, flush=4, mem_oob=3, priv=2, pc_jump=1, ipc=0.
    typedef struct packed {
        logic nmi;
        logic flush;
        logic mem_oob;
        logic priv;
        logic pc_jump;
        logic ipc;
    } anomaly_t;

    // Where a freshly counted incident sends the FSM from IDLE or COOLDOWN.
    function automatic resp_state_t dispatch(input logic [1:0] sev, input logic limit_hit);
        resp_state_t st;
        if (limit_hit) begin
            st = RESP_LOCKDOWN;
        end else begin
            case (sev)
                SEV_LOW: st = RESP_ALERT;
                SEV_MED: st = RESP_CONTAIN;
                default: st = RESP_LOCKDOWN;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/kavach_event_fifo.sv
// Synchronous first-word-fall-through FIFO for the incident log, with a sticky
// overflow flag raised whenever a push has to be dropped.
module kavach_event_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] data,
    output logic             empty,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit tells full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop_ready && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !do_pop) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone say which words are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/kavach_threat_responder.sv
// Escalating security response FSM (alert, contain, lockdown, locked) driven by
// the execution monitor, with an incident log drained over valid/ready.
module kavach_threat_responder
    import kavach_pkg::*;
#(
    parameter int          PC_WIDTH     = 32,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd1024,
    parameter logic [15:0] COOLDOWN_CYC = 16'd512,
    parameter logic [3:0]  STRIKE_LIMIT = 4'd4,
    parameter int          LOG_DEPTH    = 8,
    parameter int          LOG_AW       = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          monitor_ready,
    input  logic [$bits(anomaly_t)-1:0]   anomaly_vec,
    input  logic [1:0]                    severity,
    input  logic [PC_WIDTH-1:0]           last_bad_pc,
    input  logic                          irq_ack,
    input  logic                          sw_clear,
    input  logic                          zeroize_done,
    output logic                          sec_irq,
    output logic                          cpu_halt,
    output logic                          zeroize_req,
    output logic [2:0]                    resp_state,
    output logic [3:0]                    strike_cnt,
    output logic                          log_valid,
    input  logic                          log_ready,
    output logic [$bits(anomaly_t)+2+PC_WIDTH-1:0] log_data,
    output logic                          log_overflow
);

    localparam int LOG_W = $bits(anomaly_t) + 2 + PC_WIDTH;

    // Raw bits rather than the enum so that illegal codes 6/7 stay representable.
    logic [2:0]  state_q;
    logic [2:0]  next_state;
    logic [15:0] timer_q;
    logic [3:0]  strike_q;
    logic        sec_irq_q, cpu_halt_q, zeroize_q;
    logic        sec_irq_d, cpu_halt_d, zeroize_d;

    logic        incident;
    logic        sev_esc;
    logic        sev_high;
    logic        limit_hit;
    logic        log_push;
    logic        strike_inc;
    logic        strike_clr;
    logic        ovf_clear;
    logic        log_empty;

    assign incident  = monitor_ready && (severity != SEV_NONE);
    assign sev_esc   = monitor_ready && severity[1];
    assign sev_high  = monitor_ready && (severity == SEV_HIGH);
    assign limit_hit = ({1'b0, strike_q} + 5'd1) >= {1'b0, STRIKE_LIMIT};
    assign ovf_clear = (state_q == RESP_IDLE) && sw_clear;

    // State, timer, strike counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RESP_IDLE;
            timer_q    <= '0;
            strike_q   <= '0;
            sec_irq_q  <= 1'b0;
            cpu_halt_q <= 1'b0;
            zeroize_q  <= 1'b0;
        end else begin
            state_q    <= next_state;
            timer_q    <= (next_state != state_q) ? 16'd0 : timer_q + 16'd1;
            if (strike_inc) begin
                if (strike_q != 4'hF) strike_q <= strike_q + 4'd1;
            end else if (strike_clr) begin
                strike_q <= '0;
            end
            sec_irq_q  <= sec_irq_d;
            cpu_halt_q <= cpu_halt_d;
            zeroize_q  <= zeroize_d;
        end
    end

    always_comb begin
        // NOTE: defaults first on every comb output, otherwise unassigned paths infer latches.
        next_state = state_q;
        log_push   = 1'b0;
        strike_inc = 1'b0;
        strike_clr = 1'b0;
        case (state_q)
            RESP_IDLE: begin
                if (incident) begin
                    log_push   = 1'b1;
                    strike_inc = 1'b1;
                    next_state = dispatch(severity, limit_hit);
                end else if (sw_clear) begin
                    strike_clr = 1'b1;
                end
            end
            RESP_ALERT: begin
                // Escalation outranks an acknowledge arriving in the same cycle.
                if (sev_esc) begin
                    log_push   = 1'b1;
                    next_state = RESP_CONTAIN;
                end else if (irq_ack) begin
                    next_state = RESP_COOLDOWN;
                end else if (timer_q == ACK_TIMEOUT - 16'd1) begin
                    next_state = RESP_CONTAIN;
                end
            end
            RESP_CONTAIN: begin
                if (sev_high) begin
                    log_push   = 1'b1;
                    next_state = RESP_LOCKDOWN;
                end else if (irq_ack && sw_clear) begin
                    next_state = RESP_COOLDOWN;
                end
            end
            RESP_LOCKDOWN: begin
                if (zeroize_done) next_state = RESP_LOCKED;
            end
            RESP_LOCKED: begin
                next_state = RESP_LOCKED;
            end
            RESP_COOLDOWN: begin
                if (sev_esc) begin
                    log_push   = 1'b1;
                    strike_inc = 1'b1;
                    next_state = dispatch(severity, limit_hit);
                end else if (timer_q == COOLDOWN_CYC - 16'd1) begin
                    next_state = RESP_IDLE;
                end
            end
            default: next_state = RESP_LOCKDOWN;
        endcase
    end

    // Outputs decode the state being entered so they line up with resp_state.
    always_comb begin
        sec_irq_d  = 1'b0;
        cpu_halt_d = 1'b0;
        zeroize_d  = 1'b0;
        case (next_state)
            RESP_ALERT: begin
                sec_irq_d = 1'b1;
            end
            RESP_CONTAIN, RESP_LOCKED: begin
                sec_irq_d  = 1'b1;
                cpu_halt_d = 1'b1;
            end
            RESP_LOCKDOWN: begin
                sec_irq_d  = 1'b1;
                cpu_halt_d = 1'b1;
                zeroize_d  = 1'b1;
            end
            default: ;
        endcase
    end

    kavach_event_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH),
        .AW    (LOG_AW)
    ) u_log (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (log_push),
        .push_data ({anomaly_vec, severity, last_bad_pc}),
        .pop_ready (log_ready),
        .ovf_clear (ovf_clear),
        .data      (log_data),
        .empty     (log_empty),
        .overflow  (log_overflow)
    );

    assign sec_irq     = sec_irq_q;
    assign cpu_halt    = cpu_halt_q;
    assign zeroize_req = zeroize_q;
    assign resp_state  = state_q;
    assign strike_cnt  = strike_q;
    assign log_valid   = !log_empty;

endmodule

// File: tb/tb_kavach_threat_responder.sv
// Directed bench for kavach_threat_responder: a dispatch vector table plus
// hand-written sequences for timeouts, lockdown, strikes and log overflow.
module tb_kavach_threat_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        monitor_ready = 1'b1;
    logic [5:0]  anomaly_vec = '0;
    logic [1:0]  severity = '0;
    logic [31:0] last_bad_pc = '0;
    logic        irq_ack = 1'b0;
    logic        sw_clear = 1'b0;
    logic        zeroize_done = 1'b0;
    logic        sec_irq, cpu_halt, zeroize_req;
    logic [2:0]  resp_state;
    logic [3:0]  strike_cnt;
    logic        log_valid;
    logic        log_ready = 1'b1;
    logic [39:0] log_data;
    logic        log_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kavach_threat_responder #(
        .PC_WIDTH(32), .ACK_TIMEOUT(16'd1024), .COOLDOWN_CYC(16'd512),
        .STRIKE_LIMIT(4'd4), .LOG_DEPTH(8), .LOG_AW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .monitor_ready(monitor_ready),
        .anomaly_vec(anomaly_vec), .severity(severity), .last_bad_pc(last_bad_pc),
        .irq_ack(irq_ack), .sw_clear(sw_clear), .zeroize_done(zeroize_done),
        .sec_irq(sec_irq), .cpu_halt(cpu_halt), .zeroize_req(zeroize_req),
        .resp_state(resp_state), .strike_cnt(strike_cnt), .log_valid(log_valid),
        .log_ready(log_ready), .log_data(log_data), .log_overflow(log_overflow)
    );

    typedef struct {
        logic        rdy;
        logic [1:0]  sev;
        logic [5:0]  vec;
        logic [31:0] pc;
        logic [2:0]  exp_state;
        logic        exp_irq;
        logic        exp_halt;
        logic        exp_zreq;
        logic [3:0]  exp_strike;
        logic        exp_lvalid;
    } vec_t;

    vec_t        vecs [5];
    logic [39:0] exp_log [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge: outputs are sampled there, inputs change there.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        monitor_ready = 1'b1;
        severity = 2'b00; anomaly_vec = '0; last_bad_pc = '0;
        irq_ack = 1'b0; sw_clear = 1'b0; zeroize_done = 1'b0; log_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic incident(input logic [1:0] sev, input logic [5:0] vec, input logic [31:0] pc);
        severity = sev; anomaly_vec = vec; last_bad_pc = pc;
        @(negedge clk);
        severity = 2'b00;
    endtask

    task automatic pulse_clear();
        sw_clear = 1'b1;
        @(negedge clk);
        sw_clear = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        for (int k = 0; k < budget && resp_state !== st; k++) @(negedge clk);
        check(name, resp_state, st);
    endtask

    // Low-severity incident, acknowledged at once, then a full cooldown back to IDLE.
    task automatic alert_round(input logic [5:0] vec, input logic [31:0] pc);
        incident(2'b01, vec, pc);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        wait_state(3'd0, 600, "round_back_to_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           rdy   sev    vec       pc             st    irq   halt  zreq  strike lvalid
        vecs[0] = '{1'b0, 2'b11, 6'h3F, 32'hAAAA_0000, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[1] = '{1'b1, 2'b00, 6'h3F, 32'hAAAA_0004, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
        vecs[2] = '{1'b1, 2'b01, 6'h01, 32'hAAAA_0008, 3'd1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
        vecs[3] = '{1'b1, 2'b10, 6'h08, 32'hAAAA_000C, 3'd2, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[4] = '{1'b1, 2'b11, 6'h20, 32'hAAAA_0010, 3'd3, 1'b1, 1'b1, 1'b1, 4'd1, 1'b1};

        // Reset state.
        do_reset();
        check("rst_state", resp_state, 3'd0);
        check("rst_outs", {sec_irq, cpu_halt, zeroize_req, log_valid, log_overflow}, 5'b0);
        check("rst_strike", strike_cnt, 4'd0);

        // Dispatch table from IDLE.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            log_ready = 1'b0;
            monitor_ready = vecs[i].rdy;
            incident(vecs[i].sev, vecs[i].vec, vecs[i].pc);
            check("vec_state", resp_state, vecs[i].exp_state);
            check("vec_irq", sec_irq, vecs[i].exp_irq);
            check("vec_halt", cpu_halt, vecs[i].exp_halt);
            check("vec_zreq", zeroize_req, vecs[i].exp_zreq);
            check("vec_strike", strike_cnt, vecs[i].exp_strike);
            check("vec_lvalid", log_valid, vecs[i].exp_lvalid);
            if (vecs[i].exp_lvalid)
                check("vec_ldata", log_data, {vecs[i].vec, vecs[i].sev, vecs[i].pc});
        end

        // Alert, ack, exact 512-cycle cooldown.
        do_reset();
        log_ready = 1'b0;
        incident(2'b01, 6'b000001, 32'h1000_0040);
        check("t1_state_alert", resp_state, 3'd1);
        check("t1_irq", sec_irq, 1'b1);
        check("t1_log_valid", log_valid, 1'b1);
        check("t1_log_data", log_data, {6'b000001, 2'b01, 32'h1000_0040});
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t1_state_cooldown", resp_state, 3'd5);
        check("t1_irq_low", sec_irq, 1'b0);
        repeat (511) @(negedge clk);
        check("t1_cooldown_511", resp_state, 3'd5);
        @(negedge clk);
        check("t1_cooldown_512", resp_state, 3'd0);
        log_ready = 1'b1;
        @(negedge clk);
        check("t1_log_drained", log_valid, 1'b0);

        // Ack timeout, then CONTAIN exit needs ack and clear together.
        do_reset();
        incident(2'b01, 6'b000010, 32'h1000_0080);
        check("t2_alert", resp_state, 3'd1);
        repeat (1023) @(negedge clk);
        check("t2_alert_1023", resp_state, 3'd1);
        @(negedge clk);
        check("t2_contain_1024", resp_state, 3'd2);
        check("t2_halt", cpu_halt, 1'b1);
        check("t2_no_timeout_push", log_valid, 1'b0);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("t2_ack_alone", resp_state, 3'd2);
        irq_ack = 1'b1; sw_clear = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0; sw_clear = 1'b0;
        check("t2_cooldown", resp_state, 3'd5);
        check("t2_halt_low", cpu_halt, 1'b0);
        check("t2_strike_kept", strike_cnt, 4'd1);

        // Escalation beats ack in ALERT; high severity in CONTAIN locks down.
        do_reset();
        log_ready = 1'b0;
        incident(2'b01, 6'b000100, 32'h1000_00C0);
        irq_ack = 1'b1;
        incident(2'b10, 6'b001000, 32'h1000_00C4);
        irq_ack = 1'b0;
        check("esc_contain", resp_state, 3'd2);
        incident(2'b11, 6'b010000, 32'h1000_00C8);
        check("esc_lockdown", resp_state, 3'd3);
        check("esc_zreq", zeroize_req, 1'b1);

        // Lockdown holds until zeroize_done; LOCKED ignores everything.
        do_reset();
        incident(2'b11, 6'b100000, 32'hDEAD_0000);
        check("t3_lockdown", resp_state, 3'd3);
        check("t3_zreq", zeroize_req, 1'b1);
        repeat (50) @(negedge clk);
        check("t3_zreq_held", zeroize_req, 1'b1);
        check("t3_still_lockdown", resp_state, 3'd3);
        zeroize_done = 1'b1;
        @(negedge clk);
        zeroize_done = 1'b0;
        check("t3_locked", resp_state, 3'd4);
        check("t3_zreq_drop", zeroize_req, 1'b0);
        check("t3_locked_outs", {sec_irq, cpu_halt}, 2'b11);
        sw_clear = 1'b1; irq_ack = 1'b1; severity = 2'b11; zeroize_done = 1'b1;
        repeat (5) @(negedge clk);
        sw_clear = 1'b0; irq_ack = 1'b0; severity = 2'b00; zeroize_done = 1'b0;
        check("t3_locked_sticky", resp_state, 3'd4);
        check("t3_strike_sticky", strike_cnt, 4'd1);

        // Strike limit: fourth low incident goes straight to LOCKDOWN.
        do_reset();
        for (int i = 0; i < 3; i++) alert_round(6'b000001, 32'h3000_0000 + 32'(i));
        check("t4_strike3", strike_cnt, 4'd3);
        incident(2'b01, 6'b000001, 32'h3000_0003);
        check("t4_lockdown", resp_state, 3'd3);
        check("t4_strike4", strike_cnt, 4'd4);

        // Ten incidents into an 8-deep log with the consumer stalled.
        do_reset();
        log_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            logic [5:0]  v;
            logic [31:0] p;
            v = 6'(1 << (i % 6));
            p = 32'h2000_0000 + 32'(i * 16);
            exp_log[i] = {v, 2'b01, p};
            alert_round(v, p);
            if (i == 7) check("t5_no_ovf_at_8", log_overflow, 1'b0);
            if (i == 1 || i == 3 || i == 5 || i == 7) pulse_clear();
        end
        check("t5_overflow", log_overflow, 1'b1);
        check("t5_strike", strike_cnt, 4'd2);
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t5_drain_valid", log_valid, 1'b1);
            check("t5_drain_data", log_data, exp_log[i]);
            @(negedge clk);
        end
        check("t5_empty", log_valid, 1'b0);
        check("t5_ovf_sticky", log_overflow, 1'b1);
        pulse_clear();
        check("t5_ovf_cleared", log_overflow, 1'b0);

        // Illegal state code fails secure; async reset mid-lockdown.
        do_reset();
        force dut.state_q = 3'd6;
        @(posedge clk);
        #1;
        release dut.state_q;
        repeat (2) @(negedge clk);
        check("t6_illegal_to_lockdown", resp_state, 3'd3);
        check("t6_zreq", zeroize_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", resp_state, 3'd0);
        check("t6_rst_outs", {sec_irq, cpu_halt, zeroize_req, log_valid, log_overflow}, 5'b0);
        check("t6_rst_strike", strike_cnt, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kavach_threat_responder.md
Name: kavach_threat_responder

Overview:
- Consumes the per-cycle anomaly flags, severity code and faulting PC produced by the execution monitor.
- Escalates through a response state machine:
  - alert: raises a security interrupt;
  - contain: halts the CPU;
  - lockdown: zeroizes keys, then latches the LOCKED state until reset.
- Records every incident in a small event-log FIFO that firmware or the debug bridge drains over a valid/ready interface.

Parameters:
- PC_WIDTH, 32, width of faulting-PC field.
- ACK_TIMEOUT, 16'd1024, cycles ALERT waits for irq_ack before escalating to CONTAIN.
- COOLDOWN_CYC, 16'd512, cycles spent in COOLDOWN before returning to IDLE.
- STRIKE_LIMIT, 4'd4, incidents since last sw_clear that force LOCKDOWN.
- LOG_DEPTH, 8, event-FIFO entries (power of two).
- LOG_AW, 3, log2(LOG_DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- monitor_ready  in  1  monitor baseline valid; no incidents accepted while 0.
- anomaly_vec  in  6  {nmi, flush, mem_oob, priv, pc_jump, ipc} anomaly flags.
- severity  in  2  00 none, 01 low, 10 medium, 11 high.
- last_bad_pc  in  PC_WIDTH  faulting PC.
- irq_ack  in  1  CPU acknowledges sec_irq (level).
- sw_clear  in  1  single-cycle firmware clear pulse.
- zeroize_done  in  1  key store confirms erase.
- sec_irq  out  1  security interrupt.
- cpu_halt  out  1  stall request to core.
- zeroize_req  out  1  key-erase request.
- resp_state  out  3  current FSM state.
- strike_cnt  out  4  incidents since last clear (saturating).
- log_valid  out  1  log entry available.
- log_ready  in  1  consumer accepts entry.
- log_data  out  8+PC_WIDTH  {anomaly_vec, severity, pc}.
- log_overflow  out  1  sticky: an entry was dropped.

Behaviour:
- Reset: every output is 0; resp_state = IDLE; FIFO is empty; all counters are 0.
- State encoding: IDLE=0, ALERT=1, CONTAIN=2, LOCKDOWN=3, LOCKED=4, COOLDOWN=5.
  - Codes 6 and 7 are illegal. They go to LOCKDOWN on the next cycle (fail-secure).
- Incident definition: monitor_ready && severity != 0, sampled on a clock edge.
- IDLE:
  - On an incident: strike_cnt increments (saturating at 15) and a log entry is pushed.
  - Next state: if strike_cnt+1 >= STRIKE_LIMIT, go to LOCKDOWN. Otherwise go by severity: 01 to ALERT, 10 to CONTAIN, 11 to LOCKDOWN.
  - sw_clear in IDLE zeroes strike_cnt and log_overflow. sw_clear in other states is ignored.
- ALERT:
  - sec_irq = 1; the timer counts from 0.
  - severity >= 10: push a log entry and go to CONTAIN (escalation wins over ack in the same cycle).
  - Else irq_ack: go to COOLDOWN.
  - Else timer == ACK_TIMEOUT-1: go to CONTAIN without a log push.
- CONTAIN:
  - sec_irq = 1; cpu_halt = 1.
  - severity == 11: push a log entry and go to LOCKDOWN.
  - Else irq_ack && sw_clear in the same cycle: go to COOLDOWN.
- LOCKDOWN:
  - cpu_halt = 1; sec_irq = 1; zeroize_req = 1, held until zeroize_done.
  - On zeroize_done: go to LOCKED; zeroize_req drops in the same edge.
- LOCKED: cpu_halt = 1, sec_irq = 1. Exited only by rst_n; all inputs are ignored.
- COOLDOWN:
  - Outputs low; the timer counts from 0.
  - Severity 01 is ignored.
  - severity >= 10: push a log entry, increment strike_cnt, then apply the same dispatch as IDLE.
  - timer == COOLDOWN_CYC-1: go to IDLE.
- Outputs are registered: a state change is visible on the outputs one cycle after the deciding edge.
- Timer: one shared 16-bit timer, cleared on every state entry.
- Event log FIFO:
  - Push data = {anomaly_vec, severity, last_bad_pc} as sampled at the deciding edge.
  - First-word-fall-through: log_data is valid whenever log_valid = 1.
  - A pop occurs on log_valid && log_ready.
  - Push when full: the push is dropped and log_overflow is set, unless a pop happens in the same cycle, in which case both occur and the count is unchanged.
  - Push and pop while empty: log_valid rises the next cycle and the entry is retained.
  - Pointers are LOG_AW+1 bits with natural wrap-around.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), including dropping zeroize_req. The key store must treat a dropped request as an abort.

Decomposition:
- Shared package kavach_pkg:
  - state encodings RESP_IDLE through RESP_COOLDOWN;
  - severity codes SEV_NONE, SEV_LOW, SEV_MED, SEV_HIGH;
  - anomaly_vec bit indices.
- Sub-module kavach_event_fifo: parameterised width/depth sync FIFO with FWFT, full, empty and overflow.
- The FSM and timer live in the top-level module.

Test Plan:
- Reset, monitor_ready=1, one cycle severity=01, vec=6'b000001, pc=0x1000_0040 -> next cycle resp_state=1 and sec_irq=1; log holds {01, 01, 0x1000_0040}. Then irq_ack -> state 5; 512 cycles later -> state 0.
- ALERT with no ack -> after exactly 1024 cycles state=2 and cpu_halt=1. Assert irq_ack and sw_clear in one cycle -> state 5, cpu_halt=0.
- severity=11 from IDLE -> state 3, zeroize_req=1. Hold zeroize_done=0 for 50 cycles -> req stays high. Pulse done -> state 4. Further inputs, including sw_clear -> remain 4 until rst_n.
- Four severity=01 incidents, each acked and cooled down, with no sw_clear -> 4th incident goes directly to state 3; strike_cnt=4.
- Ten incidents with log_ready=0 -> 8 entries retained and log_overflow=1. Drain -> entries come out in order with pcs matching; sw_clear in IDLE -> overflow=0.
- Force an illegal state code via the bench -> next cycle state=3. Assert rst_n low during LOCKDOWN -> all outputs 0 and state 0.
